// File: rtl/cmm_hst2apb.sv
// cmm_hst2apb: host register requests issued as APB4 master transfers.
// Ports: hst_* request/ack side, apb_* APB4 master side, one clock.
module cmm_hst2apb #(
  parameter int         C_AW   = 32,
  parameter logic [2:0] C_PROT = 3'b000,
  parameter int         C_TMO  = 256
) (
  input  logic            apb_pclk,
  input  logic            apb_presetn,
  input  logic [3:0]      hst_sel,
  input  logic [C_AW-1:0] hst_addr,
  input  logic            hst_wen,
  input  logic [31:0]     hst_wdat,
  output logic            hst_rack,
  output logic [31:0]     hst_rdat,
  output logic            hst_err,
  output logic            hst_full,
  output logic            hst_ovf,
  output logic            apb_psel,
  output logic            apb_penable,
  output logic            apb_pwrite,
  output logic [C_AW-1:0] apb_paddr,
  output logic [31:0]     apb_pwdata,
  output logic [3:0]      apb_pwstrb,
  output logic [2:0]      apb_pprot,
  input  logic            apb_pready,
  input  logic            apb_pslverr,
  input  logic [31:0]     apb_prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit          TMO_EN   = (C_TMO != 0);
  localparam logic [15:0] TMO_LAST = 16'(C_TMO - 1);

  state_t state, state_nx;

  logic [C_AW-1:0] act_addr;
  logic            act_wen;
  logic [31:0]     act_wdat;
  logic [3:0]      act_sel;

  logic            pend_v;
  logic [C_AW-1:0] pend_addr;
  logic            pend_wen;
  logic [31:0]     pend_wdat;
  logic [3:0]      pend_sel;

  logic [15:0] cnt;

  logic req, done, tmo, fin;
  logic promote, load_new, store, drop;

  assign req  = |hst_sel;
  assign done = (state == ACCESS) && apb_pready;
  assign tmo  = (state == ACCESS) && !apb_pready
             && TMO_EN && (cnt == TMO_LAST);
  assign fin  = done | tmo;

  // Pending entry moves to the bus from IDLE or on completion;
  // a busy bridge parks one request, and a full slot drops it.
  assign promote  = pend_v && ((state == IDLE) || fin);
  assign load_new = (state == IDLE) && !pend_v && req;
  assign store    = req && !pend_v && (state != IDLE);
  assign drop     = req && pend_v;

  assign hst_full = pend_v;

  always_ff @(posedge apb_pclk or negedge apb_presetn) begin
    if (!apb_presetn) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (promote || load_new) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (fin) state_nx = pend_v ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    apb_paddr   = '0;
    apb_pwdata  = '0;
    apb_pwstrb  = '0;
    apb_pprot   = '0;
    if (state != IDLE) begin
      apb_psel    = 1'b1;
      apb_penable = (state == ACCESS);
      apb_pwrite  = act_wen;
      apb_paddr   = act_addr;
      apb_pwdata  = act_wdat;
      apb_pwstrb  = act_wen ? act_sel : 4'b0000;
      apb_pprot   = C_PROT;
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_presetn) begin
    if (!apb_presetn) begin
      act_addr  <= '0;
      act_wen   <= 1'b0;
      act_wdat  <= '0;
      act_sel   <= '0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_wen  <= 1'b0;
      pend_wdat <= '0;
      pend_sel  <= '0;
      cnt       <= '0;
      hst_rack  <= 1'b0;
      hst_rdat  <= '0;
      hst_err   <= 1'b0;
      hst_ovf   <= 1'b0;
    end else begin
      if (load_new) begin
        act_addr <= hst_addr;
        act_wen  <= hst_wen;
        act_wdat <= hst_wdat;
        act_sel  <= hst_sel;
      end else if (promote) begin
        act_addr <= pend_addr;
        act_wen  <= pend_wen;
        act_wdat <= pend_wdat;
        act_sel  <= pend_sel;
      end

      if (store) begin
        pend_v    <= 1'b1;
        pend_addr <= hst_addr;
        pend_wen  <= hst_wen;
        pend_wdat <= hst_wdat;
        pend_sel  <= hst_sel;
      end else if (promote) begin
        pend_v <= 1'b0;
      end

      if (state == SETUP)
        cnt <= '0;
      else if ((state == ACCESS) && !apb_pready)
        cnt <= cnt + 16'd1;

      hst_rack <= fin;
      hst_err  <= done ? apb_pslverr : tmo;
      hst_rdat <= (done && !act_wen) ? apb_prdata : 32'h0;
      hst_ovf  <= drop;
    end
  end

endmodule
